// File: rtl/axis_alu_pkg.sv
// axis_alu_pkg: shared types, default widths and saturation limits for the AXIS ALU stages
package axis_alu_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_FRAC_W = 16;
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] sat_max(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction
  function automatic logic [MAX_W-1:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction
endpackage

// File: rtl/IAxiStream.sv
// IAxiStream: AXI-Stream channel shared by the ALU stages
interface IAxiStream #(parameter int DATA_W = 32, parameter int ID_W = 4);
  logic tvalid;
  logic tready;
  logic tlast;
  logic [DATA_W-1:0] tdata;
  logic [ID_W-1:0] tid;
  modport Master(output tvalid, tdata, tlast, tid, input tready);
  modport Slave(input tvalid, tdata, tlast, tid, output tready);
endinterface

// File: rtl/seq_umul.sv
// seq_umul: unsigned shift-add multiplier, one multiplier bit per cycle, LSB first
module seq_umul #(
  parameter int DATA_W = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [DATA_W-1:0]     multiplicand,
  input  logic [DATA_W-1:0]     multiplier,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CW-1:0] cnt;
  // mcand shifts left each step, so it always holds multiplicand << cnt
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        mcand <= {{DATA_W{1'b0}}, multiplicand};
        mplier <= multiplier;
        product <= '0;
        cnt <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        product <= mplier[0] ? product + mcand : product;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(DATA_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/axis_multiply.sv
// axis_multiply: AXI-Stream signed fixed-point multiplier (Q.FRAC_W), iterative shift-add.
// Define AXIS_MULTIPLY_SAT_EN to saturate overflowing results instead of wrapping.
module axis_multiply
  import axis_alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic       aclk,
  input  logic       aresetn,
  IAxiStream.Slave   a,
  IAxiStream.Slave   b,
  IAxiStream.Master  result,
  output logic       ovf
);
  localparam logic [2*DATA_W-1:0] HALF = {{DATA_W{1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
  state_t state;
  logic start, done, busy, sign, r_valid, q_ovf, unused;
  logic [DATA_W-1:0] mag_a, mag_b, r, r_next, r_data;
  logic [2*DATA_W-1:0] product, q;
  assign start = aresetn && state == IDLE && a.tvalid && b.tvalid;
  assign a.tready = start;
  assign b.tready = start;
  assign mag_a = a.tdata[DATA_W-1] ? -a.tdata : a.tdata;
  assign mag_b = b.tdata[DATA_W-1] ? -b.tdata : b.tdata;
  assign unused = ^{a.tlast, a.tid, b.tlast, b.tid, busy};
  seq_umul #(.DATA_W(DATA_W)) u_mul (
    .aclk(aclk),
    .aresetn(aresetn),
    .start(start),
    .multiplicand(mag_a),
    .multiplier(mag_b),
    .busy(busy),
    .done(done),
    .product(product)
  );
  // negative results may reach one step further than positive ones
  always_comb begin
    q = product >> FRAC_W;
    r = sign ? -q[DATA_W-1:0] : q[DATA_W-1:0];
    q_ovf = sign ? q > HALF : q >= HALF;
`ifdef AXIS_MULTIPLY_SAT_EN
    r_next = q_ovf ? (sign ? DATA_W'(sat_min(DATA_W)) : DATA_W'(sat_max(DATA_W))) : r;
`else
    r_next = r;
`endif
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
      r_valid <= 1'b0;
      r_data <= '0;
      ovf <= 1'b0;
      sign <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sign <= a.tdata[DATA_W-1] ^ b.tdata[DATA_W-1];
          state <= BUSY;
        end
        BUSY: if (done) begin
          r_data <= r_next;
          ovf <= q_ovf;
          r_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (result.tready) begin
          r_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign result.tvalid = r_valid;
  assign result.tdata = r_data;
  assign result.tlast = r_valid;
  assign result.tid = '0;
endmodule

// File: tb/tb_axis_multiply.sv
// tb_axis_multiply: randomized and directed checks of axis_multiply against a signed-arithmetic model
module tb_axis_multiply;
  import axis_alu_pkg::*;
  localparam int W = 32;
  localparam int F = 16;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic ovf;
  int checks = 0;
  int failures = 0;
  IAxiStream #(.DATA_W(W)) ai();
  IAxiStream #(.DATA_W(W)) bi();
  IAxiStream #(.DATA_W(W)) ri();
  axis_multiply #(.DATA_W(W), .FRAC_W(F)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .a(ai),
    .b(bi),
    .result(ri),
    .ovf(ovf)
  );
  always #5 aclk = ~aclk;

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output logic o);
    longint p;
    longint m;
    logic [63:0] q;
    logic s;
    p = longint'($signed(a)) * longint'($signed(b));
    m = (p < 0) ? -p : p;
    q = 64'(m) >> F;
    s = a[31] ^ b[31];
    o = s ? (q > 64'h8000_0000) : (q > 64'h7FFF_FFFF);
`ifdef AXIS_MULTIPLY_SAT_EN
    d = o ? (s ? 32'h8000_0000 : 32'h7FFF_FFFF) : (s ? -q[31:0] : q[31:0]);
`else
    d = s ? -q[31:0] : q[31:0];
`endif
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int n;
    @(negedge aclk);
    ai.tvalid = 1'b1; ai.tdata = a;
    bi.tvalid = 1'b1; bi.tdata = b;
    #1;
    n = 0;
    while (!ai.tready && n < 100) begin
      @(negedge aclk); #1;
      n++;
    end
    checks++;
    if (ai.tready !== 1'b1) begin
      failures++;
      $display("FAIL handshake: a.tready=%b after %0d cycles, want 1", ai.tready, n);
    end
    @(negedge aclk);
    ai.tvalid = 1'b0;
    bi.tvalid = 1'b0;
  endtask

  task automatic await_result(output int lat, output logic [31:0] d, output logic o);
    lat = 0;
    while (ri.tvalid !== 1'b1 && lat < 200) begin
      @(negedge aclk);
      lat++;
    end
    d = ri.tdata;
    o = ovf;
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] d, ed;
    logic o, eo;
    ri.tready = 1'b1;
    model(a, b, ed, eo);
    issue(a, b);
    await_result(lat, d, o);
    checks++;
    if (d !== ed || o !== eo) begin
      failures++;
      $display("FAIL %s: a=%h b=%h got data=%h ovf=%b, want data=%h ovf=%b", name, a, b, d, o, ed, eo);
    end
    checks++;
    if (lat != W + 1 || ri.tlast !== 1'b1 || ri.tid !== '0) begin
      failures++;
      $display("FAIL %s_timing: latency=%0d tlast=%b tid=%h, want latency=%0d tlast=1 tid=0", name, lat, ri.tlast, ri.tid, W + 1);
    end
    @(negedge aclk);
    checks++;
    if (ri.tvalid !== 1'b0) begin
      failures++;
      $display("FAIL %s_consume: tvalid=%b after handshake, want 0", name, ri.tvalid);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    ai.tvalid = 1'b1; ai.tdata = 32'h0001_0000; ai.tlast = 1'b0; ai.tid = '0;
    bi.tvalid = 1'b1; bi.tdata = 32'h0001_0000; bi.tlast = 1'b0; bi.tid = '0;
    ri.tready = 1'b0;
    repeat (2) @(negedge aclk);
    checks++;
    if (ai.tready !== 1'b0 || bi.tready !== 1'b0 || ri.tvalid !== 1'b0 || ri.tdata !== '0 || ovf !== 1'b0 || dut.state !== IDLE) begin
      failures++;
      $display("FAIL reset: treadys=%b%b tvalid=%b tdata=%h ovf=%b state=%0d, want 00 0 0 0 IDLE",
               ai.tready, bi.tready, ri.tvalid, ri.tdata, ovf, dut.state);
    end
    ai.tvalid = 1'b0;
    bi.tvalid = 1'b0;
    aresetn = 1'b1;
  endtask

  task automatic test_vectors();
    check_op("mul_1p5_2", 32'h0001_8000, 32'h0002_0000);
    check_op("mul_neg1p5_2", 32'hFFFE_8000, 32'h0002_0000);
    check_op("mul_min_1", 32'h8000_0000, 32'h0001_0000);
    check_op("mul_ovf_pos", 32'h7FFF_0000, 32'h0002_0000);
    check_op("mul_ovf_neg", 32'h7FFF_0000, 32'hFFFE_0000);
    check_op("mul_zero", 32'h0000_0000, 32'h8000_0000);
    check_op("mul_min_min", 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_skew();
    int lat, n;
    logic [31:0] d, ed;
    logic o, eo;
    ri.tready = 1'b1;
    model(32'h0003_0000, 32'hFFFF_8000, ed, eo);
    @(negedge aclk);
    ai.tvalid = 1'b1; ai.tdata = 32'h0003_0000;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (ai.tready !== 1'b0 || bi.tready !== 1'b0) begin
        failures++;
        $display("FAIL skew_wait: cycle %0d treadys=%b%b, want 00", i, ai.tready, bi.tready);
      end
      @(negedge aclk);
    end
    bi.tvalid = 1'b1; bi.tdata = 32'hFFFF_8000;
    #1;
    checks++;
    if (ai.tready !== 1'b1 || bi.tready !== 1'b1) begin
      failures++;
      $display("FAIL skew_join: treadys=%b%b, want 11", ai.tready, bi.tready);
    end
    @(negedge aclk);
    ai.tvalid = 1'b0;
    bi.tvalid = 1'b0;
    await_result(lat, d, o);
    checks++;
    if (d !== ed || o !== eo || lat != W + 1) begin
      failures++;
      $display("FAIL skew_result: data=%h ovf=%b latency=%0d, want %h %b %0d", d, o, lat, ed, eo, W + 1);
    end
    @(negedge aclk);
    n = 0;
    repeat (50) begin
      if (ri.tvalid === 1'b1) n++;
      @(negedge aclk);
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL skew_single: %0d extra valid cycles, want 0", n);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] d0, d, ed;
    logic o0, o, eo;
    ri.tready = 1'b0;
    model(32'h7FFF_0000, 32'h0004_0000, ed, eo);
    issue(32'h7FFF_0000, 32'h0004_0000);
    await_result(lat, d0, o0);
    checks++;
    if (d0 !== ed || o0 !== eo) begin
      failures++;
      $display("FAIL bp_first: data=%h ovf=%b, want %h %b", d0, o0, ed, eo);
    end
    ai.tvalid = 1'b1; ai.tdata = 32'hFFFF_4000;
    bi.tvalid = 1'b1; bi.tdata = 32'h0005_0000;
    model(32'hFFFF_4000, 32'h0005_0000, ed, eo);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      checks++;
      if (ri.tvalid !== 1'b1 || ri.tdata !== d0 || ovf !== o0 || ai.tready !== 1'b0 || bi.tready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d tvalid=%b data=%h ovf=%b treadys=%b%b, want 1 %h %b 00",
                 i, ri.tvalid, ri.tdata, ovf, ai.tready, bi.tready, d0, o0);
      end
    end
    ri.tready = 1'b1;
    @(negedge aclk);
    checks++;
    if (ri.tvalid !== 1'b0 || ai.tready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: tvalid=%b a.tready=%b, want 0 1", ri.tvalid, ai.tready);
    end
    @(negedge aclk);
    ai.tvalid = 1'b0;
    bi.tvalid = 1'b0;
    await_result(lat, d, o);
    checks++;
    if (d !== ed || o !== eo || lat != W + 1) begin
      failures++;
      $display("FAIL bp_second: data=%h ovf=%b latency=%0d, want %h %b %0d", d, o, lat, ed, eo, W + 1);
    end
    @(negedge aclk);
  endtask

  task automatic test_abort();
    int n;
    ri.tready = 1'b1;
    issue(32'h0002_0000, 32'h0003_0000);
    repeat (10) @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    checks++;
    if (ri.tvalid !== 1'b0 || dut.state !== IDLE) begin
      failures++;
      $display("FAIL abort_state: tvalid=%b state=%0d, want 0 IDLE", ri.tvalid, dut.state);
    end
    n = 0;
    repeat (50) begin
      @(negedge aclk);
      if (ri.tvalid === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL abort_silent: %0d valid cycles after abort, want 0", n);
    end
    check_op("abort_next", 32'hFFFD_0000, 32'hFFFF_0000);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) != 0) a = $signed(a) >>> $urandom_range(8, 30);
      if ($urandom_range(0, 3) != 0) b = $signed(b) >>> $urandom_range(8, 30);
      check_op("random", a, b);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_skew();
    test_backpressure();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
